// File: rtl/demux_pkg.sv
// Constants shared by the demux feed FIFO and the 2-lane demultiplexer it drives.
package demux_pkg;

   localparam int DATA_WIDTH = 8;
   localparam int SEL_BIT    = 7;
   localparam int FIFO_DEPTH = 8;

   localparam logic LANE0 = 1'b0;
   localparam logic LANE1 = 1'b1;

   // True when the lane addressed by sel is currently refusing words.
   function automatic logic lane_paused(input logic sel, input logic pause0, input logic pause1);
      return (sel == LANE1) ? pause1 : pause0;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register array: synchronous write, asynchronous read.
module fifo_mem #(
   parameter int DEPTH      = demux_pkg::FIFO_DEPTH,
   parameter int DATA_WIDTH = demux_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   // NOTE: storage has no reset; the pointers and count guarantee nothing stale is ever read out.
   always_ff @(posedge clk) begin
      if (we) r_mem[waddr] <= wdata;
   end

   assign rdata = r_mem[raddr];

endmodule

// File: rtl/demux_feed_fifo.sv
// Buffering/routing stage ahead of the 2-lane demux with head-of-line pause control.
// Optional build macro DROP_COUNT_EN adds a saturating drop_count output.
module demux_feed_fifo #(
   parameter int DATA_WIDTH = demux_pkg::DATA_WIDTH,
   parameter int DEPTH      = demux_pkg::FIFO_DEPTH,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int SEL_BIT    = demux_pkg::SEL_BIT,
   parameter int AF_THRESH  = 6,
   parameter int AE_THRESH  = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  push,
   input  logic                  pause0,
   input  logic                  pause1,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out,
   output logic                  selector,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  overflow_err
`ifdef DROP_COUNT_EN
   ,output logic [7:0]           drop_count
`endif
);

   import demux_pkg::*;

   localparam int CW = ADDR_WIDTH + 1;

   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [CW-1:0]         r_count;
   logic [DATA_WIDTH-1:0] r_data_out;
   logic                  r_valid_out;
   logic                  r_selector;
   logic                  r_overflow_err;

   logic [DATA_WIDTH-1:0] w_head;
   logic                  w_head_sel;
   logic                  w_push_ok;
   logic                  w_drop;
   logic                  w_pop;

   assign full         = (r_count == CW'(DEPTH));
   assign empty        = (r_count == '0);
   assign almost_full  = (r_count >= CW'(AF_THRESH));
   assign almost_empty = (r_count <= CW'(AE_THRESH));

   fifo_mem #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk   (clk),
      .we    (w_push_ok),
      .waddr (r_wr_ptr),
      .wdata (data_in),
      .raddr (r_rd_ptr),
      .rdata (w_head)
   );

   // The head word alone decides the pop, so a paused head also blocks the other lane.
   always_comb begin
      w_head_sel = w_head[SEL_BIT];
      w_push_ok  = push && !full;
      w_drop     = push && full;
      w_pop      = !empty && !lane_paused(w_head_sel, pause0, pause1);
   end

   // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_count        <= '0;
         r_data_out     <= '0;
         r_valid_out    <= 1'b0;
         r_selector     <= 1'b0;
         r_overflow_err <= 1'b0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_drop)    r_overflow_err <= 1'b1;

         r_valid_out <= w_pop;
         if (w_pop) begin
            r_rd_ptr   <= r_rd_ptr + 1'b1;
            r_data_out <= w_head;
            r_selector <= w_head_sel;
         end

         case ({w_push_ok, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign data_out     = r_data_out;
   assign valid_out    = r_valid_out;
   assign selector     = r_selector;
   assign overflow_err = r_overflow_err;

`ifdef DROP_COUNT_EN
   logic [7:0] r_drop_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                               r_drop_count <= '0;
      else if (w_drop && r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 1'b1;
   end

   assign drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_demux_feed_fifo.sv
// Directed bench for demux_feed_fifo with an output scoreboard; covers DROP_COUNT_EN when defined.
module tb_demux_feed_fifo;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] data_in;
   logic       push;
   logic       pause0;
   logic       pause1;
   logic [7:0] data_out;
   logic       valid_out;
   logic       selector;
   logic       full;
   logic       empty;
   logic       almost_full;
   logic       almost_empty;
   logic       overflow_err;
`ifdef DROP_COUNT_EN
   logic [7:0] drop_count;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   // Expected output words as {selector, data}.
   logic [8:0] sb[$];

   always #5 clk = ~clk;

   demux_feed_fifo dut (
      .clk          (clk),
      .reset        (reset),
      .data_in      (data_in),
      .push         (push),
      .pause0       (pause0),
      .pause1       (pause1),
      .data_out     (data_out),
      .valid_out    (valid_out),
      .selector     (selector),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .overflow_err (overflow_err)
`ifdef DROP_COUNT_EN
      ,.drop_count  (drop_count)
`endif
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic enq(input logic [7:0] d);
      data_in = d;
      push    = 1'b1;
      sb.push_back({d[7], d});
   endtask

   // Every strobed word must be the next one the scoreboard expects.
   always @(negedge clk) begin
      if (!reset && valid_out) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_valid", 16'(valid_out), 16'h0);
         end else begin
            chk("sb_word", 16'({selector, data_out}), 16'(sb.pop_front()));
         end
      end
   end

   initial begin
      reset = 1'b1; data_in = '0; push = 1'b0; pause0 = 1'b0; pause1 = 1'b0;
      #12;
      chk("rst_valid", 16'(valid_out), 16'h0);
      chk("rst_data", 16'(data_out), 16'h0);
      chk("rst_sel", 16'(selector), 16'h0);
      chk("rst_empty", 16'(empty), 16'h1);
      chk("rst_full", 16'(full), 16'h0);
      chk("rst_ae", 16'(almost_empty), 16'h1);
      chk("rst_af", 16'(almost_full), 16'h0);
      chk("rst_ovf", 16'(overflow_err), 16'h0);
      tick();
      reset = 1'b0;

      // 1: two words, no pause, one-cycle latency
      enq(8'h05); tick();
      chk("t1_no_bypass", 16'(valid_out), 16'h0);
      chk("t1_not_empty", 16'(empty), 16'h0);
      enq(8'h83); tick();
      chk("t1_v1", 16'(valid_out), 16'h1);
      chk("t1_d1", 16'(data_out), 16'h05);
      chk("t1_s1", 16'(selector), 16'h0);
      push = 1'b0; tick();
      chk("t1_v2", 16'(valid_out), 16'h1);
      chk("t1_d2", 16'(data_out), 16'h83);
      chk("t1_s2", 16'(selector), 16'h1);
      tick();
      chk("t1_idle", 16'(valid_out), 16'h0);
      chk("t1_empty", 16'(empty), 16'h1);

      // 2: fill while paused, ninth push dropped
      pause0 = 1'b1; pause1 = 1'b1;
      for (int i = 0; i < 9; i++) begin
         if (i < 8) enq(8'(i));
         else begin data_in = 8'(i); push = 1'b1; end
         tick();
         if (i == 6) chk("t2_not_full", 16'(full), 16'h0);
         if (i == 7) chk("t2_full", 16'(full), 16'h1);
      end
      push = 1'b0;
      chk("t2_ovf", 16'(overflow_err), 16'h1);
      chk("t2_still_full", 16'(full), 16'h1);
      chk("t2_af", 16'(almost_full), 16'h1);
      chk("t2_paused", 16'(valid_out), 16'h0);
      pause0 = 1'b0; pause1 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("t2_drain_valid", 16'(valid_out), 16'h1);
      end
      tick();
      chk("t2_drained", 16'(empty), 16'h1);
      chk("t2_ovf_sticky", 16'(overflow_err), 16'h1);

      // 3: paused lane-1 head blocks a lane-0 word behind it
      pause1 = 1'b1;
      enq(8'h81); tick();
      enq(8'h02); tick();
      push = 1'b0;
      chk("t3_blocked", 16'(valid_out), 16'h0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t3_blocked", 16'(valid_out), 16'h0);
      end
      pause1 = 1'b0; tick();
      chk("t3_v1", 16'(valid_out), 16'h1);
      chk("t3_d1", 16'(data_out), 16'h81);
      chk("t3_s1", 16'(selector), 16'h1);
      tick();
      chk("t3_v2", 16'(valid_out), 16'h1);
      chk("t3_d2", 16'(data_out), 16'h02);
      chk("t3_s2", 16'(selector), 16'h0);
      tick();
      chk("t3_empty", 16'(empty), 16'h1);

      // 4: sustained push+pop across pointer wrap
      for (int i = 0; i < 20; i++) begin
         enq(8'hF0 + 8'(i)); tick();
         if (i > 0) chk("t4_no_gap", 16'(valid_out), 16'h1);
         chk("t4_ae", 16'(almost_empty), 16'h1);
         chk("t4_not_empty", 16'(empty), 16'h0);
      end
      push = 1'b0; tick();
      chk("t4_last_valid", 16'(valid_out), 16'h1);
      chk("t4_last_data", 16'(data_out), 16'h03);
      chk("t4_empty", 16'(empty), 16'h1);
      tick();

      // 5: fill to 6, then asynchronous reset between edges while a word is out
      pause0 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         enq(8'h10 + 8'(i)); tick();
      end
      push = 1'b0;
      chk("t5_af", 16'(almost_full), 16'h1);
      chk("t5_ae", 16'(almost_empty), 16'h0);
      chk("t5_full", 16'(full), 16'h0);
      pause0 = 1'b0; tick();
      chk("t5_pre_valid", 16'(valid_out), 16'h1);
      @(negedge clk); #2;
      reset = 1'b1;
      #1;
      sb.delete();
      chk("t5_rst_valid", 16'(valid_out), 16'h0);
      chk("t5_rst_data", 16'(data_out), 16'h0);
      chk("t5_rst_sel", 16'(selector), 16'h0);
      chk("t5_rst_empty", 16'(empty), 16'h1);
      chk("t5_rst_af", 16'(almost_full), 16'h0);
      chk("t5_rst_ovf", 16'(overflow_err), 16'h0);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t5_no_stale", 16'(valid_out), 16'h0);
         chk("t5_stay_empty", 16'(empty), 16'h1);
      end

`ifdef DROP_COUNT_EN
      // 6: drop counter saturates
      chk("t6_rst_cnt", 16'(drop_count), 16'h0);
      pause0 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         enq(8'h20 + 8'(i)); tick();
      end
      data_in = 8'h55;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (i == 9) chk("t6_cnt10", 16'(drop_count), 16'd10);
      end
      push = 1'b0;
      chk("t6_sat", 16'(drop_count), 16'hFF);
      pause0 = 1'b0;
      repeat (10) tick();
      chk("t6_drained", 16'(empty), 16'h1);
`endif

      chk("sb_leftover", 16'(sb.size()), 16'h0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/demux_feed_fifo.md
Name: demux_feed_fifo

Overview:
Buffering and routing stage directly upstream of the 2-lane demultiplexer. It accepts 8-bit words from the input stream into a small FIFO and pops them toward the demux. For each popped word it presents the data, a valid strobe and a lane selector. The selector comes from a destination bit carried in the word. Per-lane pause inputs from the downstream lanes provide head-of-line flow control.

Parameters:
DATA_WIDTH, 8, word width; the demux data path is 8 bits.
DEPTH, 8, FIFO entries; must be a power of 2.
ADDR_WIDTH, 3, log2(DEPTH).
SEL_BIT, 7, bit index of the word used as the lane selector.
AF_THRESH, 6, almost_full asserts when count >= AF_THRESH.
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH.

Ports:
clk  input  1  single clock; all flops on its rising edge.
reset  input  1  asynchronous, active-high reset.
data_in  input  DATA_WIDTH  word to enqueue.
push  input  1  enqueue request, sampled on clk rise.
pause0  input  1  lane 0 cannot accept; hold head words destined to lane 0.
pause1  input  1  lane 1 cannot accept; hold head words destined to lane 1.
data_out  output  DATA_WIDTH  word to demux dataIn; registered.
valid_out  output  1  to demux validIn; one-cycle strobe per popped word; registered.
selector  output  1  to demux selector; equals data_out[SEL_BIT] of the popped word; registered.
full  output  1  count == DEPTH.
empty  output  1  count == 0.
almost_full  output  1  count >= AF_THRESH.
almost_empty  output  1  count <= AE_THRESH.
overflow_err  output  1  sticky flag: a push was attempted while full.

Behaviour:
- Reset (asynchronous, active-high):
  - rd_ptr = 0, wr_ptr = 0, count = 0.
  - data_out = 0, valid_out = 0, selector = 0, overflow_err = 0.
  - Memory contents are not reset.
- Flag decode:
  - full, empty, almost_full and almost_empty decode combinationally from the count register only.
  - No dependence on same-cycle push or pop.
- Push:
  - Accepted when push = 1 and full = 0.
  - Accepted push: mem[wr_ptr] <= data_in, then wr_ptr increments modulo DEPTH (natural wrap).
- Push while full:
  - Word dropped; no pointer or count change; overflow_err <= 1.
  - Applies even if a pop occurs in the same cycle.
- Pop:
  - head_sel = mem[rd_ptr][SEL_BIT].
  - pop = !empty && !(head_sel ? pause1 : pause0).
  - On pop: data_out <= mem[rd_ptr], selector <= head_sel, valid_out <= 1, rd_ptr increments modulo DEPTH.
  - No pop: valid_out <= 0; data_out and selector hold their last values.
- Head-of-line blocking: a paused head blocks all following words, including those for the other lane. This is intentional and preserves order.
- Count:
  - +1 on accepted push only; -1 on pop only.
  - Unchanged when both occur or neither occurs.
- Latency:
  - A word pushed at edge E into an empty FIFO appears with valid_out = 1 after edge E+1.
  - There is no empty-bypass path.
- Throughput: one word per cycle sustained with push every cycle and no pause.
- Pause timing: pause inputs are sampled at the same edge as the pop decision. A pause asserted in cycle N suppresses the pop at the end of cycle N.
- Reset mid-operation: all queued words are discarded, valid_out drops immediately (asynchronously), and overflow_err clears.
- overflow_err clears only on reset.

Optional Feature:
DROP_COUNT_EN
- Defined:
  - Adds output port drop_count [7:0], reset to 0.
  - Increments on every dropped push and saturates at 255.
- Not defined: the port and counter are absent; overflow_err is the only drop indication.

Decomposition:
- Shared package demux_pkg:
  - DATA_WIDTH (8) and SEL_BIT (7).
  - Lane encoding constants LANE0 = 1'b0, LANE1 = 1'b1.
  - Default FIFO DEPTH.
  - The demux uses the same constants.
- Sub-module fifo_mem:
  - DEPTH x DATA_WIDTH register array.
  - Synchronous write port (we, waddr, wdata); asynchronous read port (raddr, rdata).
- Pointers, count, flags and the pop/route logic live in demux_feed_fifo.

Test Plan:
1. Reset, then push 8'h05 (cycle 1) and 8'h83 (cycle 2), no pause -> valid_out pulses in cycles 2 and 3:
   - data_out 8'h05 with selector 0, then 8'h83 with selector 1.
   - empty back to 1 afterwards.
2. Push 9 words 8'h00..8'h08 back-to-back with pause0 = pause1 = 1:
   - full = 1 after the 8th push.
   - Ninth word dropped; overflow_err = 1; count stays 8.
   - Release pauses -> 8'h00..8'h07 emerge in order.
3. Queue 8'h81, 8'h02; hold pause1 = 1 for 5 cycles:
   - No valid_out while paused (8'h02 also blocked).
   - After release: 8'h81 with selector 1, then 8'h02 with selector 0.
4. Continuous push plus pop for 20 cycles, data incrementing from 8'hF0:
   - Pointers wrap; output sequence F0, F1, ... 03 with no gaps.
   - count constant; almost_empty = 1 throughout.
5. Fill to 6 words -> almost_full = 1 and almost_empty = 0.
   - Assert reset asynchronously between clock edges -> all outputs 0 immediately.
   - empty = 1, overflow_err = 0; no stale word emerges after reset is released.
6. DROP_COUNT_EN defined: 300 pushes while full -> drop_count saturates at 8'hFF.
